// File: rtl/debug_frame_serializer.sv
// Snapshots the register-bank and data-memory buses on a start request and streams them as one
// framed byte sequence (header, optional sections, optional XOR checksum) into a UART TX FIFO.
module debug_frame_serializer #(
  parameter int                       UART_BUS_SIZE = 8,
  parameter int                       WORD_SIZE     = 32,
  parameter int                       REG_COUNT     = 32,
  parameter int                       MEM_WORDS     = 32,
  parameter logic [UART_BUS_SIZE-1:0] FRAME_HEADER  = 8'hA5
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [2:0]                     i_mode,
  input  logic                           i_uart_full,
  input  logic [REG_COUNT*WORD_SIZE-1:0] i_registers_conntent,
  input  logic [MEM_WORDS*WORD_SIZE-1:0] i_memory_conntent,
  output logic                           o_uart_wr,
  output logic [UART_BUS_SIZE-1:0]       o_uart_data_wr,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int BYTES     = WORD_SIZE / UART_BUS_SIZE;
  localparam int BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int MAX_WORDS = (REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS;
  localparam int WORD_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, HEADER, REGS, MEM, CHECK, DONE} state_t;

  state_t                           state_q, state_d;
  logic [WORD_W-1:0]                word_q, word_d;
  logic [BYTE_W-1:0]                byte_q, byte_d;
  logic [UART_BUS_SIZE-1:0]         csum_q, csum_d;
  logic                             wr_q, wr_d;
  logic [UART_BUS_SIZE-1:0]         data_q, data_d;
  logic [2:0]                       mode_q, mode_d;
  logic [REG_COUNT*WORD_SIZE-1:0]   regs_snap_q, regs_snap_d;
  logic [MEM_WORDS*WORD_SIZE-1:0]   mem_snap_q, mem_snap_d;

  logic [WORD_SIZE-1:0]     reg_words [REG_COUNT];
  logic [WORD_SIZE-1:0]     mem_words [MEM_WORDS];
  logic [WORD_SIZE-1:0]     sec_word;
  logic [UART_BUS_SIZE-1:0] sec_bytes [BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg_words
      assign reg_words[gi] = regs_snap_q[gi*WORD_SIZE +: WORD_SIZE];
    end
    for (gi = 0; gi < MEM_WORDS; gi++) begin : g_mem_words
      assign mem_words[gi] = mem_snap_q[gi*WORD_SIZE +: WORD_SIZE];
    end
    // Lane 0 is the most-significant byte so the byte counter walks MSB first.
    for (gi = 0; gi < BYTES; gi++) begin : g_lanes
      assign sec_bytes[gi] = sec_word[(BYTES-1-gi)*UART_BUS_SIZE +: UART_BUS_SIZE];
    end
  endgenerate

  assign sec_word = (state_q == MEM) ? mem_words[word_q] : reg_words[word_q];

  state_t after_header, after_regs, after_mem;
  assign after_mem    = mode_q[2] ? CHECK : DONE;
  assign after_regs   = mode_q[1] ? MEM : after_mem;
  assign after_header = mode_q[0] ? REGS : after_regs;

  logic send_state, can_send, last_byte;
  assign send_state = (state_q == HEADER) || (state_q == REGS) || (state_q == MEM) || (state_q == CHECK);
  // The idle cycle forced after every strobe gives the FIFO full flag time to update.
  assign can_send   = send_state && !i_uart_full && !wr_q;
  assign last_byte  = (byte_q == BYTE_W'(BYTES-1));

  logic [UART_BUS_SIZE-1:0] send_byte;
  logic [WORD_W-1:0]        sec_last_word;
  state_t                   sec_next;

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    byte_d        = byte_q;
    csum_d        = csum_q;
    wr_d          = 1'b0;
    data_d        = data_q;
    mode_d        = mode_q;
    regs_snap_d   = regs_snap_q;
    mem_snap_d    = mem_snap_q;
    send_byte     = FRAME_HEADER;
    sec_last_word = WORD_W'(REG_COUNT-1);
    sec_next      = after_regs;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          regs_snap_d = i_registers_conntent;
          mem_snap_d  = i_memory_conntent;
          mode_d      = i_mode;
          word_d      = '0;
          byte_d      = '0;
          csum_d      = '0;
          state_d     = HEADER;
        end
      end
      HEADER: begin
        send_byte = FRAME_HEADER;
        if (can_send) state_d = after_header;
      end
      REGS: begin
        send_byte     = sec_bytes[byte_q];
        sec_last_word = WORD_W'(REG_COUNT-1);
        sec_next      = after_regs;
      end
      MEM: begin
        send_byte     = sec_bytes[byte_q];
        sec_last_word = WORD_W'(MEM_WORDS-1);
        sec_next      = after_mem;
      end
      CHECK: begin
        send_byte = csum_q;
        if (can_send) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (can_send && ((state_q == REGS) || (state_q == MEM))) begin
      if (last_byte) begin
        byte_d = '0;
        if (word_q == sec_last_word) begin
          word_d  = '0;
          state_d = sec_next;
        end else begin
          word_d = word_q + WORD_W'(1);
        end
      end else begin
        byte_d = byte_q + BYTE_W'(1);
      end
    end

    if (can_send) begin
      wr_d   = 1'b1;
      data_d = send_byte;
      csum_d = csum_q ^ send_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_q      <= '0;
      csum_q      <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      mode_q      <= '0;
      regs_snap_q <= '0;
      mem_snap_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      csum_q      <= csum_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      regs_snap_q <= regs_snap_d;
      mem_snap_q  <= mem_snap_d;
    end
  end

  assign o_uart_wr      = wr_q;
  assign o_uart_data_wr = data_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Directed bench for debug_frame_serializer: frames are captured byte by byte and compared
// against expected frames built from the bench's own register/memory tables.
module tb_debug_frame_serializer;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [2:0]    i_mode;
  logic          i_uart_full;
  logic [1023:0] regs_bus;
  logic [1023:0] mem_bus;
  logic          o_uart_wr;
  logic [7:0]    o_uart_data_wr;
  logic          o_busy;
  logic          o_done;

  debug_frame_serializer dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_mode               (i_mode),
    .i_uart_full          (i_uart_full),
    .i_registers_conntent (regs_bus),
    .i_memory_conntent    (mem_bus),
    .o_uart_wr            (o_uart_wr),
    .o_uart_data_wr       (o_uart_data_wr),
    .o_busy               (o_busy),
    .o_done               (o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every strobed byte, count back-to-back strobes and done pulses.
  logic [7:0] cap_q[$];
  int   wr_cnt   = 0;
  int   adj_cnt  = 0;
  int   done_cnt = 0;
  logic prev_wr  = 1'b0;

  always @(negedge i_clk) begin
    if (o_uart_wr) begin
      cap_q.push_back(o_uart_data_wr);
      wr_cnt++;
      if (prev_wr) adj_cnt++;
    end
    prev_wr = o_uart_wr;
    if (o_done) done_cnt++;
  end

  logic [31:0] reg_m [32];
  logic [31:0] mem_m [32];
  logic [7:0]  exp_q[$];

  task automatic pack_buses();
    for (int k = 0; k < 32; k++) begin
      regs_bus[k*32 +: 32] = reg_m[k];
      mem_bus[k*32 +: 32]  = mem_m[k];
    end
  endtask

  task automatic build_exp(input logic [2:0] m);
    logic [7:0] cs;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'hA5;
    if (m[0]) for (int k = 0; k < 32; k++) for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(reg_m[k][b*8 +: 8]);
      cs ^= reg_m[k][b*8 +: 8];
    end
    if (m[1]) for (int k = 0; k < 32; k++) for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(mem_m[k][b*8 +: 8]);
      cs ^= mem_m[k][b*8 +: 8];
    end
    if (m[2]) exp_q.push_back(cs);
  endtask

  task automatic pulse_start(input logic [2:0] m);
    i_mode = m;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check_val({tag, "_done_seen"}, {31'd0, o_done}, 32'd1);
    @(negedge i_clk);
    check_val({tag, "_busy_drop"}, {31'd0, o_busy}, 32'd0);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic compare_frame(input string tag, input int base);
    int len = cap_q.size() - base;
    int bad = 0;
    for (int i = 0; i < len && i < exp_q.size(); i++)
      if (cap_q[base+i] !== exp_q[i]) bad++;
    check_val({tag, "_len"}, len, exp_q.size());
    check_val({tag, "_bytes_bad"}, bad, 0);
    $display("frame %s: %0d bytes captured, %0d expected, %0d byte differences", tag, len, exp_q.size(), bad);
  endtask

  initial begin
    int base, adj_base, done_base, stall_base, n;

    for (int k = 0; k < 32; k++) begin
      reg_m[k] = k;
      mem_m[k] = 32'h1000_0000 + k * 32'h0000_0101;
    end
    mem_m[0] = 32'hDEADBEEF;
    pack_buses();
    i_reset = 1'b1; i_start = 1'b0; i_mode = 3'b000; i_uart_full = 1'b0;
    repeat (3) @(negedge i_clk);
    check_val("rst_wr",   {31'd0, o_uart_wr}, 32'd0);
    check_val("rst_data", {24'd0, o_uart_data_wr}, 32'd0);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Registers only.
    base = cap_q.size(); done_base = done_cnt;
    pulse_start(3'b001);
    check_val("t1_busy_after_start", {31'd0, o_busy}, 32'd1);
    wait_done("t1");
    build_exp(3'b001);
    compare_frame("t1", base);
    check_val("t1_done_count", done_cnt - done_base, 1);

    // Registers plus checksum; strobes never adjacent.
    base = cap_q.size(); adj_base = adj_cnt;
    pulse_start(3'b101);
    wait_done("t2");
    build_exp(3'b101);
    compare_frame("t2", base);
    check_val("t2_last_byte", {24'd0, cap_q[cap_q.size()-1]}, 32'hA5);
    check_val("t2_adjacent", adj_cnt - adj_base, 0);

    // Memory only, FIFO stall after header, bus changed after start.
    base = cap_q.size();
    pulse_start(3'b010);
    mem_bus = '1;
    n = 0;
    while (wr_cnt - base < 1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check_val("t3_header_seen", wr_cnt - base, 1);
    i_uart_full = 1'b1;
    stall_base = wr_cnt;
    repeat (10) @(negedge i_clk);
    check_val("t3_stall_no_wr", wr_cnt - stall_base, 0);
    i_uart_full = 1'b0;
    wait_done("t3");
    build_exp(3'b010);
    compare_frame("t3", base);
    check_val("t3_word0", {cap_q[base+1], cap_q[base+2], cap_q[base+3], cap_q[base+4]}, 32'hDEADBEEF);
    pack_buses();

    // Header only, then header plus checksum.
    base = cap_q.size();
    pulse_start(3'b000);
    wait_done("t4a");
    build_exp(3'b000);
    compare_frame("t4a", base);
    base = cap_q.size();
    pulse_start(3'b100);
    wait_done("t4b");
    build_exp(3'b100);
    compare_frame("t4b", base);
    check_val("t4b_csum", {24'd0, cap_q[base+1]}, 32'hA5);

    // Start pulsed mid-frame is ignored; a later start runs a fresh frame.
    base = cap_q.size(); done_base = done_cnt;
    pulse_start(3'b001);
    n = 0;
    while (wr_cnt - base < 20 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    pulse_start(3'b000);
    wait_done("t5");
    build_exp(3'b001);
    compare_frame("t5", base);
    check_val("t5_done_count", done_cnt - done_base, 1);
    base = cap_q.size();
    pulse_start(3'b000);
    wait_done("t5b");
    build_exp(3'b000);
    compare_frame("t5b", base);

    // Reset mid-frame aborts immediately.
    base = wr_cnt;
    pulse_start(3'b001);
    n = 0;
    while (wr_cnt - base < 40 && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    check_val("t6_wr",   {31'd0, o_uart_wr}, 32'd0);
    check_val("t6_busy", {31'd0, o_busy}, 32'd0);
    check_val("t6_done", {31'd0, o_done}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (50) @(negedge i_clk);
    check_val("t6_byte_count", wr_cnt - base, 40);
    check_val("t6_idle_busy", {31'd0, o_busy}, 32'd0);
    $display("frame t6: reset after %0d bytes", wr_cnt - base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
